// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default widths, LRCLK channel encoding, stereo frame type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_pkg;

    localparam int AUDIO_W_DEF = 24;   // sample width per channel
    localparam int SLOT_W_DEF  = 32;   // BCLK periods per channel slot

    localparam logic LR_LEFT  = 1'b0;  // LRCLK level during the left slot
    localparam logic LR_RIGHT = 1'b1;  // LRCLK level during the right slot

    typedef struct packed {
        logic [AUDIO_W_DEF-1:0] l;
        logic [AUDIO_W_DEF-1:0] r;
    } stereo_frame_t;

endpackage

// File: rtl/edge_detect.sv
// Registered rise/fall pulse generator for a level already synchronized to clk.
// Latency: pulse is high for one clk, one clk after the level change is sampled.
// Backpressure: none; every sampled transition produces a pulse.
module edge_detect #(
    parameter logic RST_VAL = 1'b0    // assumed previous level after reset
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;
    logic r_rise;
    logic r_fall;

    // Track the previous level and register one-clk pulses on each transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= i_sig;
            r_rise <= ~r_prev & i_sig;
            r_fall <= r_prev & ~i_sig;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S DAC transmitter: shifts stereo PCM frames MSB-first with a one-BCLK delay bit.
// Latency: slot MSB reaches sdata_out one clk after the second BCLK fall of the slot.
// Backpressure: single holding register; audio_ready low while it holds an unsent frame.
// Optional: I2S_TX_HOLD_LAST_EN repeats the last frame on underrun instead of sending zeros.
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int AUDIO_W = AUDIO_W_DEF,
    parameter int SLOT_W  = SLOT_W_DEF    // must be >= AUDIO_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bclk_sync,
    input  logic               lrclk_sync,
    input  logic [AUDIO_W-1:0] audio_l_in,
    input  logic [AUDIO_W-1:0] audio_r_in,
    input  logic               audio_valid,
    output logic               audio_ready,
    output logic               sdata_out,
    output logic               underrun
);

    localparam int PAD_W = SLOT_W - AUDIO_W;
    localparam int CNT_W = $clog2(SLOT_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_W);

    // Frame waiting to be sent
    logic [AUDIO_W-1:0] r_hold_l;
    logic [AUDIO_W-1:0] r_hold_r;
    logic               r_hold_full;

    // Frame currently on the wire
    logic [AUDIO_W-1:0] r_act_l;
    logic [AUDIO_W-1:0] r_act_r;

    // Serial state
    logic [SLOT_W-1:0]  r_shreg;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_sdata;
    logic               r_lr_prev;
    logic               r_underrun;

    logic               w_fall;
    logic               w_unused_bclk_rise;
    logic               w_slot_start;
    logic               w_left_start;
    logic               w_wr_accept;
    logic [SLOT_W-1:0]  w_load_val;

    // BCLK falling edges pace every serial update.
    edge_detect #(
        .RST_VAL (1'b0)
    ) u_bclk_edge (
        .clk    (clk),
        .reset  (reset),
        .i_sig  (bclk_sync),
        .o_rise (w_unused_bclk_rise),
        .o_fall (w_fall)
    );

    assign w_slot_start = w_fall && (lrclk_sync != r_lr_prev);
    assign w_left_start = w_slot_start && (lrclk_sync == LR_LEFT);
    assign w_wr_accept  = audio_valid && !r_hold_full;

    // Word loaded into the shifter at a slot start, left-justified with zero padding.
    always_comb begin
        w_load_val = {r_act_r, {PAD_W{1'b0}}};
        if (lrclk_sync != LR_RIGHT) begin
            if (r_hold_full) begin
                w_load_val = {r_hold_l, {PAD_W{1'b0}}};
            end else begin
`ifdef I2S_TX_HOLD_LAST_EN
                w_load_val = {r_act_l, {PAD_W{1'b0}}};
`else
                w_load_val = '0;
`endif
            end
        end
    end

    // Holding register: fill on an accepted write, drain at a left-slot start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_hold_full <= 1'b0;
        end else if (w_wr_accept) begin
            r_hold_l    <= audio_l_in;
            r_hold_r    <= audio_r_in;
            r_hold_full <= 1'b1;
        end else if (w_left_start) begin
            r_hold_full <= 1'b0;
        end
    end

    // Active pair refresh at each left-slot start; flag an empty holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_act_l    <= '0;
            r_act_r    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_left_start && !r_hold_full;
            if (w_left_start && r_hold_full) begin
                r_act_l <= r_hold_l;
                r_act_r <= r_hold_r;
            end
`ifndef I2S_TX_HOLD_LAST_EN
            else if (w_left_start) begin
                r_act_l <= '0;
                r_act_r <= '0;
            end
`endif
        end
    end

    // Slot framing and MSB-first shifting on each BCLK fall; slot start emits the delay bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_sdata   <= 1'b0;
            r_lr_prev <= 1'b1;    // first observed left level counts as a slot start
        end else if (w_fall) begin
            if (w_slot_start) begin
                r_lr_prev <= lrclk_sync;
                r_bit_cnt <= '0;
                r_sdata   <= 1'b0;
                r_shreg   <= w_load_val;
            end else begin
                r_sdata <= r_shreg[SLOT_W-1];
                r_shreg <= {r_shreg[SLOT_W-2:0], 1'b0};
                if (r_bit_cnt != CNT_MAX) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    assign audio_ready = !r_hold_full;
    assign sdata_out   = r_sdata;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: codec BCLK/LRCLK model with bit scoreboard.
// Latency: n/a.
// Backpressure: source honours audio_ready.
module tb_i2s_tx_serializer;
    import i2s_pkg::*;

    logic                   clk;
    logic                   reset;
    logic                   bclk_sync;
    logic                   lrclk_sync;
    logic [AUDIO_W_DEF-1:0] audio_l_in;
    logic [AUDIO_W_DEF-1:0] audio_r_in;
    logic                   audio_valid;
    logic                   audio_ready;
    logic                   sdata_out;
    logic                   underrun;

    i2s_tx_serializer #(
        .AUDIO_W (AUDIO_W_DEF),
        .SLOT_W  (SLOT_W_DEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bclk_sync   (bclk_sync),
        .lrclk_sync  (lrclk_sync),
        .audio_l_in  (audio_l_in),
        .audio_r_in  (audio_r_in),
        .audio_valid (audio_valid),
        .audio_ready (audio_ready),
        .sdata_out   (sdata_out),
        .underrun    (underrun)
    );

    localparam stereo_frame_t FRAME_A  = {24'hA50F0F, 24'h5AF0F0};
    localparam stereo_frame_t FRAME_B1 = {24'h123456, 24'hFEDCBA};
    localparam stereo_frame_t FRAME_B2 = {24'h800001, 24'h7FFFFE};
    localparam stereo_frame_t FRAME_C  = {24'hC3C3C3, 24'h3C3C3C};
    localparam stereo_frame_t FRAME_D  = {24'h0F1E2D, 24'hF0E1D2};
    localparam stereo_frame_t FRAME_E  = {24'hA50F0F, 24'h5AF0F0};

    int            n_chk = 0;
    int            n_fail = 0;
    int            frame_cnt = 0;
    int            exp_ur = 0;
    int            ur_seen = 0;
    int            ur_long = 0;
    logic          ur_prev = 1'b0;
    bit            codec_run = 1'b0;
    bit            reset_req = 1'b0;
    bit            rst_taken = 1'b0;
    bit            rst_pend = 1'b0;
    bit            rst_done = 1'b0;
    int            div_cnt = 0;
    int            bit_idx = 0;
    bit            in_right = 1'b0;
    stereo_frame_t cur = '0;
    stereo_frame_t pend[$];
    logic          exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One slot as the codec sees it on rising BCLK: delay bit, sample MSB first, zero pad.
    task automatic push_slot(input logic [AUDIO_W_DEF-1:0] s);
        exp_q.push_back(1'b0);
        for (int i = AUDIO_W_DEF - 1; i >= 0; i--) exp_q.push_back(s[i]);
        for (int i = 0; i < SLOT_W_DEF - 1 - AUDIO_W_DEF; i++) exp_q.push_back(1'b0);
    endtask

    task automatic frame_start();
        if (pend.size() > 0) begin
            cur = pend.pop_front();
        end else begin
            exp_ur++;
`ifndef I2S_TX_HOLD_LAST_EN
            cur = '0;
`endif
        end
        push_slot(cur.l);
        push_slot(cur.r);
        frame_cnt++;
    endtask

    // Mid-left-slot reset: the rest of this frame is silent, and the next BCLK fall
    // looks like a fresh left-slot start with nothing held, so one extra underrun.
    task automatic reset_flush();
        exp_q.delete();
        pend.delete();
        cur = '0;
        for (int i = 0; i < (SLOT_W_DEF - 10) + SLOT_W_DEF; i++) exp_q.push_back(1'b0);
        exp_ur++;
    endtask

    // Codec model: BCLK = clk/8, LRCLK changes on BCLK fall, data sampled on BCLK rise.
    initial begin
        reset      = 1'b1;
        bclk_sync  = 1'b1;
        lrclk_sync = LR_LEFT;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_pend) begin
                reset    = 1'b0;
                rst_pend = 1'b0;
                rst_done = 1'b1;
                chk("midreset_sdata", sdata_out, 0);
                chk("midreset_ready", audio_ready, 1);
                chk("midreset_underrun", underrun, 0);
            end
            if (codec_run) begin
                if (div_cnt == 0) begin
                    bclk_sync = 1'b0;
                    if (bit_idx == 0) begin
                        lrclk_sync = in_right ? LR_RIGHT : LR_LEFT;
                        if (!in_right) frame_start();
                    end
                    if (reset_req && !rst_taken && !in_right && bit_idx == 10) begin
                        rst_taken = 1'b1;
                        reset     = 1'b1;
                        rst_pend  = 1'b1;
                        reset_flush();
                    end
                end else if (div_cnt == 4) begin
                    logic e;
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    else e = 1'b0;
                    chk($sformatf("sdata f%0d %s b%0d", frame_cnt, in_right ? "R" : "L", bit_idx),
                        sdata_out, e);
                    bclk_sync = 1'b1;
                    if (bit_idx == SLOT_W_DEF - 1) begin
                        bit_idx  = 0;
                        in_right = !in_right;
                    end else begin
                        bit_idx++;
                    end
                end
                div_cnt = (div_cnt + 1) % 8;
            end
        end
    end

    // Underrun pulse monitor: count pulses and any pulse longer than one clk.
    initial begin
        forever begin
            @(negedge clk);
            if (underrun === 1'b1) begin
                ur_seen++;
                if (ur_prev === 1'b1) ur_long++;
            end
            ur_prev = underrun;
        end
    end

    task automatic send(input stereo_frame_t f);
        int   waited;
        logic rdy;
        waited      = 0;
        rdy         = 1'b0;
        audio_l_in  = f.l;
        audio_r_in  = f.r;
        audio_valid = 1'b1;
        while (waited < 3000) begin
            rdy = audio_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
        end
        audio_valid = 1'b0;
        if (!rdy) begin
            chk("send_timeout", 0, 1);
        end else begin
            chk("hold_empty_at_accept", pend.size(), 0);
            pend.push_back(f);
            chk("ready_low_after_write", audio_ready, 0);
        end
    endtask

    task automatic wait_frame(input int n);
        int t;
        t = 0;
        while (frame_cnt < n && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (frame_cnt < n) chk("frame_timeout", frame_cnt, n);
    endtask

    initial begin
        int t;
        audio_valid = 1'b0;
        audio_l_in  = '0;
        audio_r_in  = '0;

        // Reset and idle with BCLK stuck high: nothing must move.
        repeat (14) @(posedge clk);
        #1;
        chk("rst_sdata", sdata_out, 0);
        chk("rst_ready", audio_ready, 1);
        chk("rst_underrun", underrun, 0);
        chk("idle_no_underrun", ur_seen, 0);

        // Frame A, then a starved frame.
        send(FRAME_A);
        codec_run = 1'b1;
        wait_frame(2);
        repeat (8) @(posedge clk);
        #1;
        chk("starve_underrun_cnt", ur_seen, exp_ur);
        chk("starve_underrun_width", ur_long, 0);

        // Back-to-back writes: the second and third wait on audio_ready.
        send(FRAME_B1);
        send(FRAME_B2);
        send(FRAME_C);

        // Reset partway through frame C's left slot.
        wait_frame(5);
        reset_req = 1'b1;
        t = 0;
        while (!rst_done && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!rst_done) chk("reset_timeout", 0, 1);
        repeat (24) @(posedge clk);
        #1;
        send(FRAME_D);
        send(FRAME_E);

        // After E the source starves: zeros, or E repeated when holding the last frame.
        wait_frame(10);
        repeat (16) @(posedge clk);
        #1;
        chk("underrun_total", ur_seen, exp_ur);
        chk("underrun_width", ur_long, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Codec-side audio transmitter for the codec unit. Runs entirely in the system clock domain.
- Consumes codec BCLK/LRCLK levels that a 2-flop synchronizer has already brought into this domain.
- Detects their edges and shifts stereo PCM frames out on the codec DAC serial line in I2S format (MSB first, one-BCLK delay).
- Upstream sample source writes frames through a valid/ready holding register.

Parameters:
- AUDIO_W, 24, sample width per channel.
- SLOT_W, 32, BCLK periods per channel slot; must satisfy SLOT_W >= AUDIO_W + 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- bclk_sync  in  1  codec BCLK, already synchronized to clk.
- lrclk_sync  in  1  codec LRCLK, already synchronized to clk; 0 = left, 1 = right.
- audio_l_in  in  AUDIO_W  left sample, two's complement.
- audio_r_in  in  AUDIO_W  right sample.
- audio_valid  in  1  frame write request.
- audio_ready  out  1  holding register empty.
- sdata_out  out  1  serial data to codec DAC.
- underrun  out  1  one-clk pulse when a frame starts with no data available.

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - sdata_out=0, audio_ready=1, underrun=0.
  - bclk_prev=0, so there is no false falling edge after reset.
  - lr_prev=1, so the first observed lrclk_sync=0 is treated as a left-slot start.
  - Shift register=0, bit counter=0, holding and active registers=0, holding empty.
- Edge detect: fall_evt = bclk_prev & ~bclk_sync, registered each clk. All serial activity happens only on fall_evt cycles.
- Clock ratio: requires clk >= 4x BCLK.
- Slot start: on fall_evt with lrclk_sync != lr_prev.
  - lr_prev <= lrclk_sync.
  - bit_cnt <= 0.
  - sdata_out <= 0 (I2S delay bit).
  - Shift register loads the channel sample left-justified in SLOT_W, zero-padded at the LSBs.
- Left-slot start (lrclk_sync=0):
  - If holding is full: active_l/active_r <= holding, holding marked empty, audio_ready <= 1. The shift register loads the new left sample.
  - If holding is empty: underrun=1 for exactly that clk. The active pair is cleared to zero, and the shift register loads zero.
- Right-slot start (lrclk_sync=1): the shift register loads active_r. Holding is not touched.
- Other fall_evt cycles:
  - sdata_out <= shreg[SLOT_W-1], shreg <<= 1 (zero fill).
  - bit_cnt increments, saturating at SLOT_W.
  - Extra BCLKs beyond SLOT_W output 0.
- Latency: MSB of a slot appears on sdata_out one clk after the second fall_evt of the slot.
- Handshake:
  - A write is accepted when audio_valid & audio_ready. It captures both channels; audio_ready <= 0 next clk.
  - audio_valid while not ready is ignored, with no side effects.
  - Write in the same clk as a left-slot start with holding empty: underrun fires, the frame is zeros, and the written data is held for the next frame.
- Mid-slot reset: all state returns to reset values next clk. Output resumes cleanly at the next left-slot start.
- Stuck BCLK: no fall_evt, so outputs are frozen and no underrun is raised.

Optional Feature:
- Macro: I2S_TX_HOLD_LAST_EN.
- Defined: on underrun, the active pair retains its previous values. The last frame repeats, and the underrun pulse still fires.
- Undefined: on underrun the active pair is cleared and a zero frame is transmitted (default above).

Decomposition:
- Shared package i2s_pkg:
  - AUDIO_W/SLOT_W defaults.
  - LR_LEFT=0 / LR_RIGHT=1 constants.
  - stereo_frame_t typedef (l, r).
- One natural sub-module: edge_detect. Registered rise/fall pulse generator, reused later by the I2S receiver.

Test Plan:
- Reset with bclk_sync=1, lrclk_sync=0 held -> sdata_out=0, audio_ready=1, underrun=0. No shifting until the first real BCLK fall.
- BCLK=clk/8. Write L=24'hA50F0F, R=24'h5AF0F0 before LRCLK falls.
  - Left slot: sdata shows delay 0, then 1010_0101_0000_1111_0000_1111, then 7 zeros.
  - Right slot: same framing for 5AF0F0.
- No write before a left-slot start -> underrun high exactly 1 clk; 64 zero bits on sdata_out.
- Write frame A, then hold audio_valid with frame B -> audio_ready=0 until A's left-slot start. B is accepted the clk after ready returns; A is transmitted unchanged.
- Assert reset at bit 10 of a left slot -> next clk sdata_out=0, audio_ready=1. Next full frame transmits correctly.
- With I2S_TX_HOLD_LAST_EN: send A5_0F0F/5A_F0F0, then starve -> underrun pulse and identical bit pattern repeated. Without the macro, a zero frame is sent.
